// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 8 data + parity + stop bits, ACK check.
// All outputs are registered. Line edges reach the FSM after a 2-flop synchronizer plus one edge-detect flop.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          err_flag_q, err_flag_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]    fall_cnt_q, fall_cnt_d;
  logic [19:0]   tmo_cnt_q, tmo_cnt_d, tmo_nxt;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          fall, counting, timeout;

  always_comb begin
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_dat_in;
    dat_s2_d   = dat_s1_q;
    fall       = clk_prev_q & ~clk_s2_q;
    counting   = (state_q == REQ) || (state_q == XFER) ||
                 (state_q == ACK) || (state_q == WAIT_IDLE);
    tmo_nxt    = tmo_cnt_q + 20'd1;
    timeout    = counting && !fall && (tmo_nxt == 20'(TIMEOUT_CYC));

    state_d    = state_q;
    data_d     = data_q;
    par_d      = par_q;
    err_flag_d = err_flag_q;
    inh_cnt_d  = inh_cnt_q;
    fall_cnt_d = fall_cnt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (send) begin
          data_d     = tx_data;
          par_d      = ~^tx_data;
          err_flag_d = 1'b0;
          busy_d     = 1'b1;
          clk_oe_d   = 1'b1;
          dat_oe_d   = 1'b0;
          inh_cnt_d  = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + IW'(1);
        if (inh_cnt_q == IW'(INHIBIT_CYC - 1)) begin
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Start bit stays driven (dat_oe=1) while the clock is handed to the device.
        clk_oe_d   = 1'b0;
        fall_cnt_d = '0;
        state_d    = XFER;
      end
      XFER: begin
        if (fall) begin
          fall_cnt_d = fall_cnt_q + 4'd1;
          case (fall_cnt_q)
            4'd8:    dat_oe_d = ~par_q;
            4'd9: begin
              dat_oe_d = 1'b0;
              state_d  = ACK;
            end
            default: dat_oe_d = ~data_q[fall_cnt_q[2:0]];
          endcase
        end
      end
      ACK: begin
        if (fall) begin
          err_flag_d = err_flag_q | dat_s2_q;
          state_d    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          err_d   = err_flag_q;
          busy_d  = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (timeout) begin
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      err_flag_d = 1'b1;
      done_d     = 1'b1;
      err_d      = 1'b1;
      busy_d     = 1'b0;
      state_d    = FINISH;
    end

    // Restart the timeout window on every device edge and on every state change.
    if (!counting || fall || (state_d != state_q)) tmo_cnt_d = '0;
    else                                           tmo_cnt_d = tmo_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      data_q     <= '0;
      par_q      <= 1'b0;
      err_flag_q <= 1'b0;
      inh_cnt_q  <= '0;
      fall_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      data_q     <= data_d;
      par_q      <= par_d;
      err_flag_q <= err_flag_d;
      inh_cnt_q  <= inh_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device that clocks frames and ACKs/NACKs.
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TMO = 1500;
  localparam int HP  = 12;

  typedef struct {
    logic [7:0] d;
    logic       ack;
    logic [8:0] exp_line;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, send, ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
  logic [7:0] tx_data;
  logic       dev_clk, dev_dat;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   inh_total = 0;
  int   req_total = 0;
  int   done_total = 0;
  int   done_cyc = 0;
  int   dat_chg_cyc = 0;
  logic done_err = 1'b0;
  logic done_busy = 1'b0;
  logic prev_dat_oe = 1'b0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_clk_oe && !ps2_dat_oe) inh_total <= inh_total + 1;
    if (ps2_clk_oe && ps2_dat_oe)  req_total <= req_total + 1;
    if ((ps2_dat_oe !== prev_dat_oe) && !done) dat_chg_cyc <= cyc;
    prev_dat_oe <= ps2_dat_oe;
    if (done) begin
      done_total <= done_total + 1;
      done_err   <= err;
      done_busy  <= busy;
      done_cyc   <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Issue one command and play the device side for nfalls clock pulses.
  task automatic run_txn(input string tag, input logic [7:0] d, input logic ack,
                         input int nfalls, input int poke_fall, output logic [9:0] seen);
    int n;
    seen = '0;
    @(negedge clk);
    tx_data = d;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check1({tag, "_busy_after_send"}, busy, 1'b1);
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_reach_xfer"}, n < 4 * INH, 1'b1);
    check1({tag, "_start_bit"}, ps2_dat_in, 1'b0);
    for (int i = 1; i <= nfalls; i++) begin
      repeat (HP) @(negedge clk);
      if (i == 11 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      if (i <= 10) seen[i-1] = ps2_dat_in;
      if (i == poke_fall) begin
        tx_data = 8'h00;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
      dev_clk = 1'b1;
    end
    if (nfalls == 11) begin
      repeat (HP) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_done(input string tag, input int base);
    int n;
    n = 0;
    while (done_total == base && n < TMO + 500) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_done_seen"}, done_total != base, 1'b1);
  endtask

  task automatic run_full(input string tag, input logic [7:0] d, input logic ack,
                          input logic [8:0] exp_line, input logic exp_err, input int poke);
    int         base_done, base_inh, base_req;
    logic [9:0] seen;
    base_done = done_total;
    base_inh  = inh_total;
    base_req  = req_total;
    run_txn(tag, d, ack, 11, poke, seen);
    wait_done(tag, base_done);
    check({tag, "_line_bits"}, 32'(seen), 32'({1'b1, exp_line}));
    check({tag, "_done_count"}, done_total - base_done, 1);
    check1({tag, "_err"}, done_err, exp_err);
    check1({tag, "_busy_at_done"}, done_busy, 1'b0);
    check({tag, "_inhibit_cycles"}, inh_total - base_inh, INH);
    check({tag, "_req_cycles"}, req_total - base_req, 1);
    check1({tag, "_clk_oe_idle"}, ps2_clk_oe, 1'b0);
    check1({tag, "_dat_oe_idle"}, ps2_dat_oe, 1'b0);
  endtask

  initial begin
    vec_t       vt[6];
    int         base_done, base_inh, n;
    logic [9:0] seen;

    // Expected line levels after falls 1..9 = {odd parity, data}, LSB first.
    vt[0] = '{8'hF4, 1'b1, 9'h0F4, 1'b0};
    vt[1] = '{8'hFF, 1'b0, 9'h1FF, 1'b1};
    vt[2] = '{8'h00, 1'b1, 9'h100, 1'b0};
    vt[3] = '{8'hA5, 1'b1, 9'h1A5, 1'b0};
    vt[4] = '{8'h01, 1'b0, 9'h001, 1'b1};
    vt[5] = '{8'hED, 1'b1, 9'h1ED, 1'b0};

    reset   = 1'b0;
    send    = 1'b0;
    tx_data = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    check1("reset_clk_oe", ps2_clk_oe, 1'b0);
    check1("reset_dat_oe", ps2_dat_oe, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_err", err, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Device-to-host clocking while idle must not start anything.
    base_done = done_total;
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HP) @(negedge clk);
    end
    check1("idle_falls_busy", busy, 1'b0);
    check1("idle_falls_clk_oe", ps2_clk_oe, 1'b0);
    check("idle_falls_done", done_total - base_done, 0);

    for (int v = 0; v < 6; v++)
      run_full($sformatf("vec%0d", v), vt[v].d, vt[v].ack, vt[v].exp_line, vt[v].exp_err, 0);

    // Device stops after fall 5: timeout must fire TMO cycles after the host reacted to fall 5.
    base_done = done_total;
    run_txn("tmo", 8'hF4, 1'b1, 5, 0, seen);
    wait_done("tmo", base_done);
    check("tmo_bits", 32'(seen[4:0]), 32'h14);
    check1("tmo_err", done_err, 1'b1);
    check("tmo_latency", done_cyc - dat_chg_cyc, TMO);
    check1("tmo_clk_oe", ps2_clk_oe, 1'b0);
    check1("tmo_dat_oe", ps2_dat_oe, 1'b0);
    check1("tmo_busy", busy, 1'b0);

    // A second send during XFER is ignored; no follow-on transfer.
    run_full("poke", 8'hF4, 1'b1, 9'h0F4, 1'b0, 3);
    base_done = done_total;
    base_inh  = inh_total;
    repeat (3 * INH) @(negedge clk);
    check("poke_no_second_done", done_total - base_done, 0);
    check("poke_no_second_inhibit", inh_total - base_inh, 0);
    check1("poke_idle_busy", busy, 1'b0);

    // Reset in the middle of INHIBIT aborts silently.
    base_done = done_total;
    base_inh  = inh_total;
    @(negedge clk);
    tx_data = 8'hF4;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while ((inh_total - base_inh) < INH / 2 && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
    check1("rst_mid_reached_inhibit", n < 4 * INH, 1'b1);
    #2 reset = 1'b0;
    #1;
    check1("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
    check1("rst_mid_dat_oe", ps2_dat_oe, 1'b0);
    check1("rst_mid_busy", busy, 1'b0);
    check1("rst_mid_done", done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3 * INH) @(negedge clk);
    check("rst_mid_no_done", done_total - base_done, 0);
    check1("rst_mid_idle_clk_oe", ps2_clk_oe, 1'b0);
    run_full("post_rst", 8'hF4, 1'b1, 9'h0F4, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Parameters
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000, the number of clk cycles PS2 clock is held low before the request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 750000, the maximum clk cycles allowed between device falling edges (15 ms at 50 MHz).

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port send, input, 1 bit: command request, sampled in IDLE only.
REQ-006 SHALL have port tx_data, input, 8 bits: command byte, captured when send is accepted.
REQ-007 SHALL have ports ps2_clk_in and ps2_dat_in, input, 1 bit each: raw PS2 line levels (asynchronous).
REQ-008 SHALL have port ps2_clk_oe, output, 1 bit: 1 = drive the PS2 clock line low, 0 = release it.
REQ-009 SHALL have port ps2_dat_oe, output, 1 bit: 1 = drive the PS2 data line low, 0 = release it.
REQ-010 SHALL have port busy, output, 1 bit: high from acceptance until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: valid only with done; 1 = NACK or timeout.

Function
REQ-013 SHALL synchronize ps2_clk_in and ps2_dat_in through 2 flops each; "fall" = previous synced clock 1 and current synced clock 0.
REQ-014 SHALL implement states IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, and FINISH.
REQ-015 In IDLE, send=1 SHALL capture tx_data, compute odd parity (~^tx_data), and enter INHIBIT; busy SHALL be 1 from the next cycle.
REQ-016 send while busy=1 SHALL be ignored, with no effect on the transfer in progress.
REQ-017 In INHIBIT, ps2_clk_oe=1 and ps2_dat_oe=0 for exactly INHIBIT_CYC cycles, then SHALL enter REQ.
REQ-018 In REQ, ps2_clk_oe=1 and ps2_dat_oe=1 for 1 cycle (start bit), then SHALL enter XFER with ps2_clk_oe=0 and ps2_dat_oe held at 1.
REQ-019 In XFER, a 4-bit fall counter SHALL drive the data line at each fall:
- falls 1-8: ps2_dat_oe = ~tx_data[n-1] (LSB first)
- fall 9: ps2_dat_oe = ~parity
- fall 10: ps2_dat_oe = 0 (stop bit), then enter ACK.
REQ-020 In ACK, at the next fall the synced data SHALL be sampled: 0 = ACK, 1 = NACK (sets the error flag); then enter WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL wait until synced clock = 1 and synced data = 1, then enter FINISH.
REQ-022 FINISH SHALL assert done=1 for one cycle with err = error flag, set busy=0, and return to IDLE.
REQ-023 A 20-bit timeout counter SHALL clear on every fall and on each state entry, and count in REQ, XFER, ACK, and WAIT_IDLE.
REQ-024 When the timeout counter reaches TIMEOUT_CYC, the block SHALL release both lines, set the error flag, and enter FINISH.
REQ-025 In IDLE, FINISH, and WAIT_IDLE, ps2_clk_oe=0 and ps2_dat_oe=0.
REQ-026 ps2_clk_oe SHALL never be 1 outside INHIBIT and REQ.
REQ-027 Falls observed in IDLE (device-to-host traffic) SHALL be ignored.
REQ-028 The error flag SHALL clear on acceptance of send.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=0, all counters 0, synchronizers 1, and the error flag 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the next send after reset release SHALL start a fresh INHIBIT.

Verification
REQ-031 Send 0xF4; device model clocks 11 falls and pulls data low at fall 11 -> ps2_clk_oe high for 5000 cycles; data after falls 1-9 = 0,0,1,0,1,1,1,1,0; done=1, err=0.
REQ-032 Send 0xFF with the device leaving data high at fall 11 (NACK) -> parity bit 1; done=1, err=1.
REQ-033 Send 0xF4 with the device stopping after fall 5 -> done=1, err=1 exactly 750000 cycles after fall 5; both oe outputs = 0.
REQ-034 Assert send with 0x00 during the XFER of 0xF4 -> the line sequence and done for 0xF4 are unchanged; no second transfer follows.
REQ-035 Assert reset during INHIBIT at cycle 2000 -> both oe outputs = 0 and busy=0 immediately; no done; the following send 0xF4 completes normally.
